imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 28 ++
 rtl/imem_responder.sv | 106 ++++++++++
 tb/tb_imem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction memory responder: request, response,
// redirect flush and program-load write port.
interface imem_responder_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    // Fetch stage / loader side
    modport master (
        output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: word-addressed program RAM with a load port
// and a 2-entry in-order response FIFO. Misaligned or out-of-range fetches
// return NOP_WORD with the error flag set.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input logic              clk,
    input logic              reset,
    imem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   fifo_addr_q [2];
    logic [31:0]   fifo_word_q [2];
    logic          fifo_err_q  [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;

    logic          can_accept;
    logic          push;
    logic          pop;
    logic          rsp_valid;
    logic [AW-1:0] req_idx;
    logic          req_err;
    logic [31:0]   req_word;
    logic [AW-1:0] ld_idx;
    logic          ld_hit;

    // Request decode: byte address -> word index, error on misalignment or
    // any address bit above the memory range
    assign req_idx  = bus.req_addr[AW+1:2];
    assign req_err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);
    assign req_word = req_err ? NOP_WORD : mem_q[req_idx];

    assign ld_idx   = bus.ld_addr[AW+1:2];
    assign ld_hit   = bus.ld_en && (bus.ld_addr[1:0] == 2'b00)
                      && (bus.ld_addr[31:AW+2] == '0);

    assign can_accept = (count_q != 2'd2) && !bus.flush && !bus.ld_en;
    assign push       = bus.req_valid && can_accept;
    assign rsp_valid  = (count_q != 2'd0);
    assign pop        = rsp_valid && bus.rsp_ready && !bus.flush;

    // Reset is folded into ready so nothing is advertised while held low
    assign bus.req_ready = reset && can_accept;
    assign bus.rsp_valid = rsp_valid;
    // Head fields are gated by occupancy so an async reset clears them at once
    assign bus.rsp_inst  = rsp_valid ? fifo_word_q[rd_ptr_q] : '0;
    assign bus.rsp_addr  = rsp_valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign bus.rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

    // FIFO pointer and occupancy next-state; flush empties the FIFO outright
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO entry storage, written on an accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_word_q[i] <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
        end else if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.req_addr;
            fifo_word_q[wr_ptr_q] <= req_word;
            fifo_err_q[wr_ptr_q]  <= req_err;
        end
    end

    // Program memory load port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ld_hit) begin
            mem_q[ld_idx] <= bus.ld_data;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
    localparam int DEPTH = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    imem_responder_if bus();

    imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        fl;
        logic        le;
        logic [31:0] la;
        logic [31:0] ld;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    rsp_t        mq[$];
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] a);
        rsp_t r;
        r.addr = a;
        r.err  = (a % 4 != 0) || (a >= 4 * DEPTH);
        r.word = r.err ? NOP : mdl_mem[a / 4];
        return r;
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, ".rsp_valid"}, {31'b0, bus.rsp_valid}, {31'b0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk({tag, ".rsp_addr"}, bus.rsp_addr, mq[0].addr);
            chk({tag, ".rsp_err"}, {31'b0, bus.rsp_err}, {31'b0, mq[0].err});
            if (mq[0].err || mdl_known[mq[0].addr / 4])
                chk({tag, ".rsp_inst"}, bus.rsp_inst, mq[0].word);
        end
    endtask

    // One clock: drive at edge+1, check ready at edge+3, update model at edge, check outputs at edge+1
    task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr,
                         input logic fl, input logic le, input logic [31:0] la,
                         input logic [31:0] ld, input string tag, output logic rdy_seen);
        logic exp_rdy;
        bus.req_valid = rv; bus.req_addr = ra; bus.rsp_ready = rr;
        bus.flush = fl; bus.ld_en = le; bus.ld_addr = la; bus.ld_data = ld;
        #2;
        exp_rdy = rst_n && (mq.size() < 2) && !fl && !le;
        chk({tag, ".req_ready"}, {31'b0, bus.req_ready}, {31'b0, exp_rdy});
        rdy_seen = bus.req_ready;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (mq.size() > 0 && rr) void'(mq.pop_front());
            if (rv && exp_rdy) mq.push_back(mk(ra));
        end
        if (le && (la % 4 == 0) && (la < 4 * DEPTH)) begin
            mdl_mem[la / 4]   = ld;
            mdl_known[la / 4] = 1'b1;
        end
        #1;
        chk_outputs(tag);
    endtask

    vec_t vt[$];

    function automatic vec_t v(input logic rv, input logic [31:0] ra, input logic rr,
                               input logic fl, input logic le, input logic [31:0] la,
                               input logic [31:0] ld, input logic er, input logic ev,
                               input logic [31:0] ei, input logic [31:0] ea, input logic ee);
        vec_t x;
        x.rv = rv; x.ra = ra; x.rr = rr; x.fl = fl; x.le = le; x.la = la; x.ld = ld;
        x.exp_ready = er; x.exp_valid = ev; x.exp_inst = ei; x.exp_addr = ea; x.exp_err = ee;
        return x;
    endfunction

    initial begin
        logic r;
        for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = '0; bus.rsp_ready = 1'b1;
        bus.flush = 1'b0; bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        #3;
        chk("reset.req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("reset.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset.rsp_inst", bus.rsp_inst, 32'd0);
        chk("reset.rsp_addr", bus.rsp_addr, 32'd0);
        chk("reset.rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        bus.req_valid = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        //   rv  ra        rr fl le la       ld            rdy val inst          addr     err
        vt.push_back(v(1, 32'h0,   0, 0, 1, 32'h0, 32'h0050_0093, 0, 0, 0, 0, 0));
        vt.push_back(v(0, 32'h0,   0, 0, 1, 32'h4, 32'h0000_0113, 0, 0, 0, 0, 0));
        vt.push_back(v(0, 32'h0,   0, 0, 1, 32'h8, 32'h0020_8193, 0, 0, 0, 0, 0));
        vt.push_back(v(0, 32'h0,   0, 0, 1, 32'h6, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h0,   1, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0050_0093, 32'h0, 0));
        vt.push_back(v(1, 32'h4,   1, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0000_0113, 32'h4, 0));
        vt.push_back(v(1, 32'h2,   1, 0, 0, 32'h0, 32'h0,         1, 1, NOP,           32'h2, 1));
        vt.push_back(v(1, 32'h400, 1, 0, 0, 32'h0, 32'h0,         1, 1, NOP,           32'h400, 1));
        vt.push_back(v(0, 32'h0,   1, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h0,   0, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0050_0093, 32'h0, 0));
        vt.push_back(v(1, 32'h4,   0, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0050_0093, 32'h0, 0));
        vt.push_back(v(1, 32'h8,   0, 0, 0, 32'h0, 32'h0,         0, 1, 32'h0050_0093, 32'h0, 0));
        vt.push_back(v(1, 32'h8,   1, 0, 0, 32'h0, 32'h0,         0, 1, 32'h0000_0113, 32'h4, 0));
        vt.push_back(v(1, 32'h8,   1, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0020_8193, 32'h8, 0));
        vt.push_back(v(0, 32'h0,   1, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h0,   0, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0050_0093, 32'h0, 0));
        vt.push_back(v(1, 32'h8,   0, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0050_0093, 32'h0, 0));
        vt.push_back(v(1, 32'hC,   1, 1, 0, 32'h0, 32'h0,         0, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h4,   0, 0, 0, 32'h0, 32'h0,         1, 1, 32'h0000_0113, 32'h4, 0));
        vt.push_back(v(0, 32'h0,   1, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            cycle(vt[i].rv, vt[i].ra, vt[i].rr, vt[i].fl, vt[i].le, vt[i].la, vt[i].ld, tg, r);
            chk({tg, ".tbl_ready"}, {31'b0, r}, {31'b0, vt[i].exp_ready});
            chk({tg, ".tbl_valid"}, {31'b0, bus.rsp_valid}, {31'b0, vt[i].exp_valid});
            if (vt[i].exp_valid) begin
                chk({tg, ".tbl_inst"}, bus.rsp_inst, vt[i].exp_inst);
                chk({tg, ".tbl_addr"}, bus.rsp_addr, vt[i].exp_addr);
                chk({tg, ".tbl_err"}, {31'b0, bus.rsp_err}, {31'b0, vt[i].exp_err});
            end
        end

        // Asynchronous reset between edges with two responses buffered
        cycle(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, "arst_fill0", r);
        cycle(1, 32'h4, 0, 0, 0, 32'h0, 32'h0, "arst_fill1", r);
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        chk("arst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("arst.req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("arst.rsp_inst", bus.rsp_inst, 32'd0);
        chk("arst.rsp_addr", bus.rsp_addr, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.after_valid", {31'b0, bus.rsp_valid}, 32'd0);
        cycle(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, "arst_fetch", r);
        chk("arst.mem_kept", bus.rsp_inst, 32'h0050_0093);
        cycle(0, 32'h0, 1, 0, 0, 32'h0, 32'h0, "arst_drain", r);

        // Fill the whole memory with random words, then random traffic
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 32'h0, 1, 0, 1, 32'(i * 4), $urandom, "fill", r);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra, la;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 7) ra = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
            else if (sel == 8) ra = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
            else               ra = $urandom;
            sel = $urandom_range(0, 3);
            if (sel < 3) la = 32'($urandom_range(0, DEPTH - 1) * 4);
            else         la = $urandom;
            cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                  la, $urandom, "rand", r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
